out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Clocked round-robin arbiter sharing one router output port among five requesters: the four routing outputs of the path computation stage (one from each neighbour input) and the local core injection path. Each requester offers an 11-bit packet {7-bit payload, 4-bit destination address} with a valid/ready handshake. The block grants one requester per cycle, registers the winning packet into a single-entry output stage, and hands it to the link with a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 11, packet width in bits ({payload[6:0], addr[3:0]}); passed through unmodified.
- NREQ, 5, number of requesters; index 0..3 = router inputs, 4 = core.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NREQ  requester i offers a packet.
- req_data  in  NREQ*WIDTH  packet of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot or zero; requester i's packet is taken on this edge.
- out_valid  out  1  output register holds a packet.
- out_data  out  WIDTH  held packet.
- out_ready  in  1  downstream accepts out_data this edge.
- grant_id  out  3  index of requester whose packet is in the output register.
- pkt_count  out  16  total packets accepted since reset, wraps modulo 2^16.

## Operation
- State: output register (out_valid, out_data, grant_id), priority pointer ptr (0..NREQ-1), pkt_count.
- accept = !out_valid || out_ready. The output register can load this cycle.
- Winner: first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping NREQ-1 -> 0.
- req_ready[winner] = accept && (any req_valid), combinational from req_valid, ptr and out_valid/out_ready. All other bits are 0. No valid requests gives req_ready = 0.
- On an edge with a grant:
  - out_data <= winner's data.
  - grant_id <= winner.
  - out_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
  - pkt_count <= pkt_count+1.
- On an edge with out_valid && out_ready and no grant: out_valid <= 0. out_data and grant_id keep their last values.
- Without a grant, ptr does not move.
- While out_valid && !out_ready, out_data and grant_id are stable and req_ready = 0.
- Requesters must hold req_valid and req_data until they see req_ready. The arbiter does not latch requests.
- Fairness: any requester continuously valid is granted within NREQ grants.

## Timing
- Reset (rst=1 at an edge): out_valid=0, out_data=0, grant_id=0, ptr=0, pkt_count=0. req_ready is 0 during the reset cycle.
- Reset mid-operation discards a held packet with no output handshake.
- Latency: a packet accepted at edge N is visible on out_data with out_valid=1 after edge N.
- Throughput: with out_ready held at 1, one packet per cycle. A drain and a load happen on the same edge, so out_valid stays 1.
- Simultaneous drain and load: the new packet replaces the old one and pkt_count increments.
- Pointer wrap: a grant to index NREQ-1 sets ptr=0.
- pkt_count wraps from 16'hFFFF to 16'h0000.
- Backpressure: out_ready=0 for any number of cycles. out_data is stable and no requester is granted.

## Test plan
- Reset, then idle: out_valid=0, req_ready=5'b00000, pkt_count=0 for 10 cycles.
- Single requester: req_valid=5'b00100 with data 11'b1111000_0100 and out_ready=1. Required:
  - req_ready=5'b00100 in the same cycle.
  - Next cycle: out_data=11'b1111000_0100, grant_id=2, ptr=3, pkt_count=1.
- Round-robin sweep: all five valid with distinct data, out_ready=1. Grants occur in order 0,1,2,3,4,0 on consecutive cycles, out_valid stays 1 and pkt_count=6 after 6 grants.
- Backpressure: output holds a packet from requester 1, out_ready=0 for 5 cycles while requesters 0 and 3 are valid. Required:
  - req_ready=0 and out_data is unchanged for those cycles.
  - When out_ready=1, the next grant is 3 (ptr=2), then 0.
- Reset mid-operation: out_valid=1, ptr=3, pkt_count=7, then rst for 1 cycle. All outputs return to their reset values, and the first grant after reset with all valid is 0.
- Counter wrap: force 65536 grants (or preload via long run). pkt_count reads 16'h0000 after the 65536th accept.

Source files
------------

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one router output port among NREQ requesters.
// The winning packet is registered into a single-entry output stage with a valid/ready handoff.
module out_port_arbiter #(
  parameter int WIDTH = 11,
  parameter int NREQ  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic                  o_out_valid,
  output logic [WIDTH-1:0]      o_out_data,
  input  logic                  i_out_ready,
  output logic [2:0]            o_grant_id,
  output logic [15:0]           o_pkt_count
);

  logic [2:0]       r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_grant_id;
  logic [15:0]      r_pkt_count;

  logic             w_accept;
  logic             w_found;
  logic [2:0]       w_winner;
  logic             w_grant;
  logic [2:0]       w_ptr_next;
  logic [WIDTH-1:0] w_win_data;

  assign w_accept = !r_out_valid || i_out_ready;

  // Scan from the priority pointer upward, wrapping past NREQ-1 back to 0.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = 3'(idx);
      end
    end
  end

  // Reset gates the grant so no requester believes its packet was taken.
  assign w_grant    = w_accept && w_found && !i_rst;
  assign w_ptr_next = (w_winner == 3'(NREQ - 1)) ? 3'd0 : w_winner + 3'd1;
  assign w_win_data = i_req_data[int'(w_winner)*WIDTH +: WIDTH];

  always_comb begin
    o_req_ready = '0;
    if (w_grant) o_req_ready[w_winner] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant_id  <= '0;
      r_pkt_count <= '0;
    end else if (w_grant) begin
      r_out_data  <= w_win_data;
      r_grant_id  <= w_winner;
      r_out_valid <= 1'b1;
      r_ptr       <= w_ptr_next;
      r_pkt_count <= r_pkt_count + 16'd1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_grant_id  = r_grant_id;
  assign o_pkt_count = r_pkt_count;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: reset, single grant, round-robin sweep,
// backpressure, mid-operation reset and packet counter wrap.
module tb_out_port_arbiter;

  localparam int WIDTH = 11;
  localparam int NREQ  = 5;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [2:0]            grant_id;
  logic [15:0]           pkt_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] d [NREQ];

  out_port_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .i_out_ready (out_ready),
    .o_grant_id  (grant_id),
    .o_pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < NREQ; i++) begin
      d[i] = {7'(7'h10 + 7'(i * 9)), 4'(i + 3)};
      req_data[i*WIDTH +: WIDTH] = d[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 5'b11111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 5'b00000) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 00000", req_ready);
    end
    tick();
    tick();
    req_valid = 5'b00000;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 5'b00000 || pkt_count !== 16'd0) begin
        errors++;
        $display("FAIL idle cycle %0d got valid=%b ready=%b cnt=%0d want 0/00000/0",
                 c, out_valid, req_ready, pkt_count);
      end
      tick();
    end
  endtask

  task automatic test_single();
    req_data[2*WIDTH +: WIDTH] = 11'b1111000_0100;
    req_valid = 5'b00100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 5'b00100) begin
      errors++;
      $display("FAIL single_ready got %b want 00100", req_ready);
    end
    tick();
    req_valid = 5'b00000;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 11'b1111000_0100 || grant_id !== 3'd2 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL single_out got v=%b d=%b id=%0d cnt=%0d want 1/11110000100/2/1",
               out_valid, out_data, grant_id, pkt_count);
    end
    // Drain with no new request: valid drops, data holds.
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 11'b1111000_0100 || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL single_drain got v=%b d=%b id=%0d want 0/11110000100/2",
               out_valid, out_data, grant_id);
    end
    // ptr should now be 3: with 0,1,3 valid, 3 wins.
    load_data();
    req_valid = 5'b01011;
    #1;
    checks++;
    if (req_ready !== 5'b01000) begin
      errors++;
      $display("FAIL single_ptr3 got %b want 01000", req_ready);
    end
    tick();
    // ptr now 4: with 0,1 valid the scan wraps to 0.
    req_valid = 5'b00011;
    #1;
    checks++;
    if (req_ready !== 5'b00001) begin
      errors++;
      $display("FAIL single_wrap_scan got %b want 00001", req_ready);
    end
    tick();
    req_valid = 5'b00000;
  endtask

  task automatic test_sweep();
    int w;
    load_data();
    do_reset();
    out_ready = 1'b1;
    req_valid = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      w = g % NREQ;
      #1;
      checks++;
      if (req_ready !== 5'(1 << w)) begin
        errors++;
        $display("FAIL sweep_ready g=%0d got %b want %b", g, req_ready, 5'(1 << w));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d[w] || grant_id !== 3'(w) || pkt_count !== 16'(g + 1)) begin
        errors++;
        $display("FAIL sweep_out g=%0d got v=%b d=%h id=%0d cnt=%0d want 1/%h/%0d/%0d",
                 g, out_valid, out_data, grant_id, pkt_count, d[w], w, g + 1);
      end
    end
    req_valid = 5'b00000;
  endtask

  task automatic test_backpressure();
    // After the sweep ptr=1; grant requester 1 alone.
    req_valid = 5'b00010;
    out_ready = 1'b1;
    tick();
    req_valid = 5'b01001;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 5'b00000 || out_valid !== 1'b1 || out_data !== d[1] || grant_id !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold c=%0d got rdy=%b v=%b d=%h id=%0d want 00000/1/%h/1",
                 c, req_ready, out_valid, out_data, grant_id, d[1]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 5'b01000) begin
      errors++;
      $display("FAIL bp_release_ready got %b want 01000", req_ready);
    end
    tick();
    req_valid = 5'b00001;
    checks++;
    if (grant_id !== 3'd3 || out_data !== d[3] || pkt_count !== 16'd8) begin
      errors++;
      $display("FAIL bp_grant3 got id=%0d d=%h cnt=%0d want 3/%h/8", grant_id, out_data, pkt_count, d[3]);
    end
    tick();
    req_valid = 5'b00000;
    checks++;
    if (grant_id !== 3'd0 || out_data !== d[0] || out_valid !== 1'b1 || pkt_count !== 16'd9) begin
      errors++;
      $display("FAIL bp_grant0 got id=%0d d=%h v=%b cnt=%0d want 0/%h/1/9",
               grant_id, out_data, out_valid, pkt_count, d[0]);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b1;
    req_valid = 5'b11111;
    repeat (6) tick();
    req_valid = 5'b00100;
    tick();
    out_ready = 1'b0;
    req_valid = 5'b11111;
    #1;
    checks++;
    if (out_valid !== 1'b1 || grant_id !== 3'd2 || pkt_count !== 16'd7) begin
      errors++;
      $display("FAIL mid_setup got v=%b id=%0d cnt=%0d want 1/2/7", out_valid, grant_id, pkt_count);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 5'b00000) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 00000", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 11'd0 || grant_id !== 3'd0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst_state got v=%b d=%h id=%0d cnt=%0d want 0/000/0/0",
               out_valid, out_data, grant_id, pkt_count);
    end
    checks++;
    if (req_ready !== 5'b00001) begin
      errors++;
      $display("FAIL mid_rst_first got %b want 00001", req_ready);
    end
    tick();
    checks++;
    if (grant_id !== 3'd0 || out_data !== d[0] || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL mid_rst_grant got id=%0d d=%h cnt=%0d want 0/%h/1", grant_id, out_data, pkt_count, d[0]);
    end
    req_valid = 5'b00000;
  endtask

  task automatic test_count_wrap();
    do_reset();
    out_ready = 1'b1;
    req_valid = 5'b00001;
    repeat (65535) tick();
    checks++;
    if (pkt_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_pre got %h want ffff", pkt_count);
    end
    tick();
    checks++;
    if (pkt_count !== 16'h0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap got cnt=%h v=%b want 0000/1", pkt_count, out_valid);
    end
    req_valid = 5'b00000;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_backpressure();
    test_mid_reset();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
